// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Definitions shared by the MIPS32 program loader and its sub-module:
//   - INSTR_W     : instruction word width
//   - OPC_*       : opcodes the loader and its users care about
//   - ld_state_e  : loader FSM state encoding
// ----------------------------------------------------------------------------
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OPC_ADD  = 6'h00;
  localparam logic [5:0] OPC_OR   = 6'h03;
  localparam logic [5:0] OPC_ADDI = 6'h0a;
  localparam logic [5:0] OPC_HLT  = 6'h3f;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_START = 3'd3,
    ST_ERR   = 3'd4
  } ld_state_e;

endpackage

// File: rtl/mips_word_assembler.sv
// ----------------------------------------------------------------------------
// mips_word_assembler
// Collects bytes into a big-endian 32-bit word: the first byte of a word ends
// up in bits 31:24. A 2-bit byte counter flags the 4th byte of each word.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   accept_i   in   a byte is transferred this cycle
//   clear_i    in   drop any partial word and restart at byte 0
//   in_data_i  in   byte being transferred
//   word_o     out  shift register contents (complete word once word_done_o)
//   word_done_o out high on the cycle the 4th byte of a word is accepted
// ----------------------------------------------------------------------------
module mips_word_assembler
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               accept_i,
  input  logic               clear_i,
  input  logic [7:0]         in_data_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_done_o
);

  logic [1:0]         cnt_q, cnt_d;
  logic [INSTR_W-1:0] sr_q,  sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear_i) begin
      cnt_d = 2'd0;
      sr_d  = '0;
    end else if (accept_i) begin
      // Counter wraps 3 -> 0 so the next word starts cleanly.
      cnt_d = cnt_q + 2'd1;
      sr_d  = {sr_q[INSTR_W-9:0], in_data_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign word_o      = sr_q;
  assign word_done_o = accept_i && (cnt_q == 2'd3);

endmodule

// File: rtl/mips_prog_loader.sv
// ----------------------------------------------------------------------------
// mips_prog_loader
// Streams a program into the MIPS32 instruction memory and then releases the
// core. Bytes arrive over a valid/ready handshake, are packed big-endian into
// 32-bit words and written to consecutive word addresses from 0. Writing the
// HLT word ends the load with a one-cycle cpu_start pulse; filling the memory
// without a HLT ends it with a sticky overflow_err and the core kept on hold.
//
// Handshake: a byte moves on every rising edge where in_valid && in_ready.
// The producer may hold in_valid low for any number of cycles; in_ready is
// high only in LOAD and never depends on in_valid.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request a load (ignored unless idle)
//   in_valid/in_data  byte stream input, in_ready back-pressure
//   mem_we/mem_addr/mem_wdata  instruction memory write port
//   cpu_hold          keeps the core halted while high
//   cpu_start         one-cycle release pulse (PC, HALTED, TAKEN_BRANCH clear)
//   busy              high outside IDLE
//   word_count        words written in the current or last load
//   overflow_err      sticky: memory full without HLT
//   dbg_state         current FSM state, for observation only
// MAX_WORDS must not exceed 2**ADDR_W.
// ----------------------------------------------------------------------------
module mips_prog_loader
  import mips_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter int         MAX_WORDS = 1024,
  parameter logic [5:0] HLT_OPC   = OPC_HLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               cpu_start,
  output logic               busy,
  output logic [ADDR_W:0]    word_count,
  output logic               overflow_err,
  output ld_state_e          dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);

  ld_state_e state_q, state_d;

  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [ADDR_W:0]    word_count_q, word_count_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               overflow_err_q, overflow_err_d;

  logic               start_acc;
  logic               accept;
  logic [INSTR_W-1:0] word;
  logic               word_done;
  logic               is_hlt;
  logic               at_last;

  assign start_acc = start && (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign is_hlt    = (word[31:26] == HLT_OPC);
  assign at_last   = (mem_addr_q == LAST_ADDR);

  // Clearing on an accepted start also throws away bytes left over from a
  // load that was interrupted, so every load starts at byte 0.
  mips_word_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_i    (accept),
    .clear_i     (start_acc),
    .in_data_i   (in_data),
    .word_o      (word),
    .word_done_o (word_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  if (word_done) state_d = ST_WRITE;
      ST_WRITE: begin
        // HLT wins over the full-memory check: a HLT in the last slot is a
        // complete program, not an overflow.
        if (is_hlt)       state_d = ST_START;
        else if (at_last) state_d = ST_ERR;
        else              state_d = ST_LOAD;
      end
      ST_START: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    cpu_start = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      ST_IDLE:  busy      = 1'b0;
      ST_LOAD:  in_ready  = 1'b1;
      ST_WRITE: mem_we    = 1'b1;
      ST_START: cpu_start = 1'b1;
      ST_ERR:   ;
      default:  busy      = 1'b0;
    endcase
  end

  // Load bookkeeping: address, word count, core hold and error flag.
  always_comb begin
    mem_addr_d     = mem_addr_q;
    word_count_d   = word_count_q;
    cpu_hold_d     = cpu_hold_q;
    overflow_err_d = overflow_err_q;

    if (start_acc) begin
      mem_addr_d     = '0;
      word_count_d   = '0;
      cpu_hold_d     = 1'b1;
      overflow_err_d = 1'b0;
    end

    if (state_q == ST_WRITE) begin
      word_count_d = word_count_q + (ADDR_W+1)'(1);
      // The address only advances when another word will follow, so after
      // the load it still names the last word written.
      if (state_d == ST_LOAD) mem_addr_d     = mem_addr_q + ADDR_W'(1);
      if (state_d == ST_ERR)  overflow_err_d = 1'b1;
    end

    // Release the core on the edge that leaves START for IDLE.
    if (state_q == ST_START) cpu_hold_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q     <= '0;
      word_count_q   <= '0;
      cpu_hold_q     <= 1'b1;
      overflow_err_q <= 1'b0;
    end else begin
      mem_addr_q     <= mem_addr_d;
      word_count_q   <= word_count_d;
      cpu_hold_q     <= cpu_hold_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  // While in WRITE the shift register holds the complete word (in_ready is
  // low so it cannot shift), so it drives the write data directly.
  assign mem_wdata    = word;
  assign mem_addr     = mem_addr_q;
  assign word_count   = word_count_q;
  assign cpu_hold     = cpu_hold_q;
  assign overflow_err = overflow_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_mips_prog_loader
// Two loaders share clock and reset: u_big (1024 words) runs the main
// program, u_small (4 words) exercises the overflow and last-slot HLT cases.
// A reference model turns a word list into the expected memory writes and
// final status; monitors compare every observed write against it.
// ----------------------------------------------------------------------------
module tb_mips_prog_loader;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        b_start, b_valid, b_ready, b_we, b_hold, b_cstart, b_busy, b_ovf;
  logic [7:0]  b_data;
  logic [9:0]  b_addr;
  logic [31:0] b_wdata;
  logic [10:0] b_wc;
  logic [2:0]  b_dbg;

  logic        s_start, s_valid, s_ready, s_we, s_hold, s_cstart, s_busy, s_ovf;
  logic [7:0]  s_data;
  logic [9:0]  s_addr;
  logic [31:0] s_wdata;
  logic [10:0] s_wc;
  logic [2:0]  s_dbg;

  mips_prog_loader #(.ADDR_W(10), .MAX_WORDS(1024)) u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .cpu_hold(b_hold), .cpu_start(b_cstart), .busy(b_busy), .word_count(b_wc),
    .overflow_err(b_ovf), .dbg_state(b_dbg)
  );

  mips_prog_loader #(.ADDR_W(10), .MAX_WORDS(4)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_data(s_data),
    .in_ready(s_ready), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
    .cpu_hold(s_hold), .cpu_start(s_cstart), .busy(s_busy), .word_count(s_wc),
    .overflow_err(s_ovf), .dbg_state(s_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [41:0] exp_b_q[$];   // {addr, data}
  logic [41:0] exp_s_q[$];
  int starts_b = 0, starts_s = 0;
  bit prev_hlt_b = 0, prev_hlt_s = 0;
  logic [41:0] e_b, e_s;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (b_cstart) begin
      starts_b++;
      check("b_start_after_hlt_write", 64'(prev_hlt_b), 64'd1);
    end
    if (b_we) begin
      check("b_ready_in_write", 64'(b_ready), 64'd0);
      if (exp_b_q.size() == 0) check("b_unexpected_write", 64'd1, 64'd0);
      else begin
        e_b = exp_b_q.pop_front();
        check("b_wr_addr", 64'(b_addr), 64'(e_b[41:32]));
        check("b_wr_data", 64'(b_wdata), 64'(e_b[31:0]));
      end
    end
    prev_hlt_b = b_we && (b_wdata[31:26] == 6'h3f);
  end

  always @(negedge clk) begin
    if (s_cstart) begin
      starts_s++;
      check("s_start_after_hlt_write", 64'(prev_hlt_s), 64'd1);
    end
    if (s_we) begin
      check("s_ready_in_write", 64'(s_ready), 64'd0);
      if (exp_s_q.size() == 0) check("s_unexpected_write", 64'd1, 64'd0);
      else begin
        e_s = exp_s_q.pop_front();
        check("s_wr_addr", 64'(s_addr), 64'(e_s[41:32]));
        check("s_wr_data", 64'(s_wdata), 64'(e_s[31:0]));
      end
    end
    prev_hlt_s = s_we && (s_wdata[31:26] == 6'h3f);
  end

  // ---------------- reference model ----------------
  // Words go to addresses 0,1,2,...; a HLT ends the load with a release,
  // reaching the last slot without HLT ends it with an overflow.
  task automatic model_load(input int sel, input logic [31:0] words[$], input int max_words,
                            output int wc, output bit ovf, output int st, output bit hold);
    logic [9:0] a;
    wc = 0; ovf = 0; st = 0;
    for (int i = 0; i < words.size(); i++) begin
      a = 10'(i);
      if (sel == 0) exp_b_q.push_back({a, words[i]});
      else          exp_s_q.push_back({a, words[i]});
      wc++;
      if (words[i][31:26] == 6'h3f) begin st = 1; break; end
      if (i == max_words - 1)       begin ovf = 1; break; end
    end
    hold = (st == 0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3f) w[31:26] = 6'h00;
    return w;
  endfunction

  // ---------------- driver tasks (entered at posedge+1) ----------------
  function automatic logic get_ready(input int sel); return (sel == 0) ? b_ready : s_ready; endfunction
  function automatic logic get_busy(input int sel);  return (sel == 0) ? b_busy  : s_busy;  endfunction

  task automatic set_byte(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin b_valid = v; b_data = d; end
    else          begin s_valid = v; s_data = d; end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) b_start = v; else s_start = v;
  endtask

  task automatic do_start(input int sel);
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] d, input bit gaps);
    bit ok;
    if (gaps && $urandom_range(0, 2) == 0) begin
      set_byte(sel, 1'b0, 8'($urandom));
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    set_byte(sel, 1'b1, d);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (get_ready(sel)) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    set_byte(sel, 1'b0, 8'h00);
    if (!ok) check("byte_accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic send_words(input int sel, input logic [31:0] words[$], input int lo,
                            input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++)
      for (int b = 3; b >= 0; b--) send_byte(sel, words[i][b*8 +: 8], gaps);
  endtask

  task automatic wait_idle(input int sel);
    for (int i = 0; i < 300; i++) begin
      if (!get_busy(sel)) break;
      @(posedge clk); #1;
    end
    check("idle_timeout", 64'(get_busy(sel)), 64'd0);
  endtask

  task automatic check_final(input int sel, input int wc, input bit ovf, input bit hold,
                             input int st);
    if (sel == 0) begin
      check("b_word_count", 64'(b_wc), 64'(wc));
      check("b_overflow_err", 64'(b_ovf), 64'(ovf));
      check("b_cpu_hold", 64'(b_hold), 64'(hold));
      check("b_start_pulses", 64'(starts_b), 64'(st));
      check("b_writes_missing", 64'(exp_b_q.size()), 64'd0);
    end else begin
      check("s_word_count", 64'(s_wc), 64'(wc));
      check("s_overflow_err", 64'(s_ovf), 64'(ovf));
      check("s_cpu_hold", 64'(s_hold), 64'(hold));
      check("s_start_pulses", 64'(starts_s), 64'(st));
      check("s_writes_missing", 64'(exp_s_q.size()), 64'd0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] prog[$];
    logic [31:0] w[$];
    int  exp_wc, exp_st, acc;
    bit  exp_ovf, exp_hold;

    b_start = 0; b_valid = 0; b_data = 0;
    s_start = 0; s_valid = 0; s_data = 0;
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(b_ready), 64'd0);
    check("rst_mem_we", 64'(b_we), 64'd0);
    check("rst_mem_addr", 64'(b_addr), 64'd0);
    check("rst_mem_wdata", 64'(b_wdata), 64'd0);
    check("rst_cpu_hold", 64'(b_hold), 64'd1);
    check("rst_cpu_start", 64'(b_cstart), 64'd0);
    check("rst_busy", 64'(b_busy), 64'd0);
    check("rst_word_count", 64'(b_wc), 64'd0);
    check("rst_overflow", 64'(b_ovf), 64'd0);
    check("rst_s_cpu_hold", 64'(s_hold), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference program, back-to-back bytes.
    starts_b = 0;
    model_load(0, prog, 1024, exp_wc, exp_ovf, exp_st, exp_hold);
    do_start(0);
    check("b_busy_after_start", 64'(b_busy), 64'd1);
    send_words(0, prog, 0, prog.size() - 1, 1'b0);
    wait_idle(0);
    check_final(0, exp_wc, exp_ovf, exp_hold, exp_st);
    check("b_last_addr", 64'(b_addr), 64'd8);

    // Same program with random in_valid gaps; reload reasserts cpu_hold.
    starts_b = 0;
    model_load(0, prog, 1024, exp_wc, exp_ovf, exp_st, exp_hold);
    do_start(0);
    check("b_hold_reasserted", 64'(b_hold), 64'd1);
    send_words(0, prog, 0, prog.size() - 1, 1'b1);
    wait_idle(0);
    check_final(0, exp_wc, exp_ovf, exp_hold, exp_st);

    // Small memory: 4 non-HLT words overflow; a 5th word is refused.
    starts_s = 0;
    w = {};
    for (int i = 0; i < 4; i++) w.push_back(rand_word());
    model_load(1, w, 4, exp_wc, exp_ovf, exp_st, exp_hold);
    do_start(1);
    send_words(1, w, 0, 3, 1'b1);
    wait_idle(1);
    check_final(1, exp_wc, exp_ovf, exp_hold, exp_st);
    set_byte(1, 1'b1, 8'hab);
    acc = 0;
    repeat (8) begin
      @(negedge clk);
      if (s_ready) acc++;
    end
    @(posedge clk); #1;
    set_byte(1, 1'b0, 8'h00);
    check("s_no_accept_after_err", 64'(acc), 64'd0);
    do_start(1);
    check("s_ovf_cleared_by_start", 64'(s_ovf), 64'd0);

    // Small memory: HLT in the last slot releases the core.
    starts_s = 0;
    w = {};
    for (int i = 0; i < 3; i++) w.push_back(rand_word());
    w.push_back({6'h3f, 26'($urandom)});
    model_load(1, w, 4, exp_wc, exp_ovf, exp_st, exp_hold);
    send_words(1, w, 0, 3, 1'b1);
    wait_idle(1);
    check_final(1, exp_wc, exp_ovf, exp_hold, exp_st);

    // Reset in the middle of the second word.
    starts_b = 0;
    w = {};
    w.push_back(rand_word());
    model_load(0, w, 1024, exp_wc, exp_ovf, exp_st, exp_hold);
    do_start(0);
    send_words(0, w, 0, 0, 1'b0);
    send_byte(0, 8'($urandom), 1'b0);
    send_byte(0, 8'($urandom), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(b_busy), 64'd0);
    check("arst_in_ready", 64'(b_ready), 64'd0);
    check("arst_mem_we", 64'(b_we), 64'd0);
    check("arst_mem_addr", 64'(b_addr), 64'd0);
    check("arst_word_count", 64'(b_wc), 64'd0);
    check("arst_cpu_hold", 64'(b_hold), 64'd1);
    check("arst_mem_wdata", 64'(b_wdata), 64'd0);
    check("arst_first_word_written", 64'(exp_b_q.size()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    starts_b = 0;
    w = {};
    for (int i = 0; i < 5; i++) w.push_back(rand_word());
    w.push_back({6'h3f, 26'($urandom)});
    model_load(0, w, 1024, exp_wc, exp_ovf, exp_st, exp_hold);
    do_start(0);
    send_words(0, w, 0, 5, 1'b1);
    wait_idle(0);
    check_final(0, exp_wc, exp_ovf, exp_hold, exp_st);

    // start during a load is ignored.
    starts_b = 0;
    w = {};
    for (int i = 0; i < 5; i++) w.push_back(rand_word());
    w.push_back({6'h3f, 26'($urandom)});
    model_load(0, w, 1024, exp_wc, exp_ovf, exp_st, exp_hold);
    do_start(0);
    send_words(0, w, 0, 1, 1'b0);
    do_start(0);
    check("b_wc_not_reset_by_start", 64'(b_wc), 64'd2);
    check("b_busy_mid_load", 64'(b_busy), 64'd1);
    send_words(0, w, 2, 5, 1'b1);
    wait_idle(0);
    check_final(0, exp_wc, exp_ovf, exp_hold, exp_st);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
